// File: rtl/tcm_axis_tx.sv
//-----------------------------------------------------------------------------
// tcm_axis_tx
//
// AXI-Stream master that emits test packets for the TCM test IP. Each beat
// carries {packet_count, beat_index} in TDATA[31:0], so a receiver (or the
// companion AXI-Stream slave, in loopback) can check the stream without
// knowing anything else. Packets are never truncated: once started, a packet
// runs to its TLAST beat regardless of what ENABLE does.
//
// Optional build macro:
//   TCM_AXIS_TX_GAP_EN  - when defined, the GAP field of the control word
//                         inserts idle cycles between continuous packets.
//                         When undefined, continuous packets are always
//                         back-to-back and the GAP field is ignored.
//
// Ports:
//   M_AXIS_ACLK        in   clock, rising edge
//   M_AXIS_ARESETN     in   asynchronous active-low reset
//   USR_tcm_control    in   [0] ENABLE, [1] CONTINUOUS, [7:4] GAP,
//                           [31:16] LEN (beats per packet = LEN+1)
//   M_AXIS_TVALID      out  beat valid
//   M_AXIS_TDATA       out  beat data, bits above 31 are zero
//   M_AXIS_TSTRB       out  all ones while TVALID=1, zero otherwise
//   M_AXIS_TLAST       out  last beat of packet
//   M_AXIS_TREADY      in   downstream ready
//   USR_tcm_busy       out  high whenever the FSM is not idle
//   USR_tcm_pkt_count  out  completed packets, wraps at 16 bits
//-----------------------------------------------------------------------------
module tcm_axis_tx #(
   parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
   input  logic                                M_AXIS_ACLK,
   input  logic                                M_AXIS_ARESETN,
   input  logic [31:0]                         USR_tcm_control,
   output logic                                M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
   output logic                                M_AXIS_TLAST,
   input  logic                                M_AXIS_TREADY,
   output logic                                USR_tcm_busy,
   output logic [15:0]                         USR_tcm_pkt_count
);

   localparam int STRB_W = C_M_AXIS_TDATA_WIDTH / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
`ifdef TCM_AXIS_TX_GAP_EN
      ST_GAP  = 2'd3,
`endif
      ST_DONE = 2'd2
   } state_t;

   // Control word fields
   logic        ctl_enable;
   logic        ctl_continuous;
   logic [15:0] ctl_len;

   assign ctl_enable     = USR_tcm_control[0];
   assign ctl_continuous = USR_tcm_control[1];
   assign ctl_len        = USR_tcm_control[31:16];

`ifdef TCM_AXIS_TX_GAP_EN
   logic [3:0] ctl_gap;
   assign ctl_gap = USR_tcm_control[7:4];

   logic unused_ctl;
   assign unused_ctl = ^{USR_tcm_control[15:8], USR_tcm_control[3:2]};
`else
   logic unused_ctl;
   assign unused_ctl = ^USR_tcm_control[15:2];
`endif

   // State
   state_t      state_reg;
   logic [15:0] len_q_reg;
   logic [15:0] beat_reg;
   logic [15:0] pkt_count_reg;
   logic        tvalid_reg;
   logic        tlast_reg;
   logic [31:0] tdata_reg;
   logic        busy_reg;
`ifdef TCM_AXIS_TX_GAP_EN
   logic [3:0]  gap_cnt_reg;
`endif

   logic [15:0] beat_inc;
   logic [15:0] pkt_inc;

   assign beat_inc = beat_reg + 16'd1;
   assign pkt_inc  = pkt_count_reg + 16'd1;

   // The FSM only ever updates TDATA/TLAST on a handshake or when entering
   // SEND, so they hold naturally under backpressure. TLAST is kept equal to
   // (beat == len_q) by precomputing it for the beat about to be presented.
   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         state_reg     <= ST_IDLE;
         len_q_reg     <= '0;
         beat_reg      <= '0;
         pkt_count_reg <= '0;
         tvalid_reg    <= 1'b0;
         tlast_reg     <= 1'b0;
         tdata_reg     <= '0;
         busy_reg      <= 1'b0;
`ifdef TCM_AXIS_TX_GAP_EN
         gap_cnt_reg   <= '0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (ctl_enable) begin
                  state_reg  <= ST_SEND;
                  busy_reg   <= 1'b1;
                  len_q_reg  <= ctl_len;
                  beat_reg   <= '0;
                  tvalid_reg <= 1'b1;
                  tdata_reg  <= {pkt_count_reg, 16'h0000};
                  tlast_reg  <= (ctl_len == 16'h0000);
               end
            end

            ST_SEND: begin
               // TVALID is always high in SEND, so TREADY alone is the handshake
               if (M_AXIS_TREADY) begin
                  if (tlast_reg) begin
                     pkt_count_reg <= pkt_inc;
                     if (ctl_enable && ctl_continuous) begin
`ifdef TCM_AXIS_TX_GAP_EN
                        if (ctl_gap != 4'd0) begin
                           // Counter runs gap-1 .. 0, one idle cycle per value
                           state_reg   <= ST_GAP;
                           tvalid_reg  <= 1'b0;
                           tlast_reg   <= 1'b0;
                           gap_cnt_reg <= ctl_gap - 4'd1;
                        end else
`endif
                        begin
                           // Back-to-back: next packet's first beat follows at once
                           len_q_reg <= ctl_len;
                           beat_reg  <= '0;
                           tdata_reg <= {pkt_inc, 16'h0000};
                           tlast_reg <= (ctl_len == 16'h0000);
                        end
                     end else begin
                        state_reg  <= ST_DONE;
                        tvalid_reg <= 1'b0;
                        tlast_reg  <= 1'b0;
                     end
                  end else begin
                     beat_reg  <= beat_inc;
                     tdata_reg <= {pkt_count_reg, beat_inc};
                     tlast_reg <= (beat_inc == len_q_reg);
                  end
               end
            end

`ifdef TCM_AXIS_TX_GAP_EN
            ST_GAP: begin
               if (gap_cnt_reg != 4'd0) begin
                  gap_cnt_reg <= gap_cnt_reg - 4'd1;
               end else if (ctl_enable) begin
                  state_reg  <= ST_SEND;
                  len_q_reg  <= ctl_len;
                  beat_reg   <= '0;
                  tvalid_reg <= 1'b1;
                  tdata_reg  <= {pkt_count_reg, 16'h0000};
                  tlast_reg  <= (ctl_len == 16'h0000);
               end else begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end
`endif

            ST_DONE: begin
               // Single-shot re-arms only after ENABLE has been seen low
               if (!ctl_enable) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end

            default: begin
               state_reg  <= ST_IDLE;
               busy_reg   <= 1'b0;
               tvalid_reg <= 1'b0;
               tlast_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign M_AXIS_TVALID     = tvalid_reg;
   assign M_AXIS_TLAST      = tlast_reg;
   assign M_AXIS_TDATA      = C_M_AXIS_TDATA_WIDTH'(tdata_reg);
   assign USR_tcm_busy      = busy_reg;
   assign USR_tcm_pkt_count = pkt_count_reg;

   genvar gi;
   generate
      for (gi = 0; gi < STRB_W; gi++) begin : g_strb
         assign M_AXIS_TSTRB[gi] = tvalid_reg;
      end
   endgenerate

endmodule

// File: doc/tcm_axis_tx.md
# tcm_axis_tx

AXI-Stream master that generates test packets for the TCM test IP. It is the transmit counterpart of the existing AXI-Stream slave. It is driven by the same 32-bit `USR_tcm_control` word, which the AXI-Lite register block produces, and it emits packets with a deterministic, checkable data pattern. It sits beside the slave in the IP top level, and its stream output can be looped back into the slave for self-test.

## Interface
- `C_M_AXIS_TDATA_WIDTH`, 32: stream data width. Must be a multiple of 8 and ≥32. Bits above 31 are driven 0.
- `M_AXIS_ACLK` in 1: single clock, rising edge.
- `M_AXIS_ARESETN` in 1: reset, asynchronous, active-low.
- `USR_tcm_control` in 32: control word.
  - [0] ENABLE
  - [1] CONTINUOUS
  - [7:4] GAP
  - [31:16] LEN; beats per packet = LEN+1.
  - Other bits ignored.
- `M_AXIS_TVALID` out 1: beat valid.
- `M_AXIS_TDATA` out C_M_AXIS_TDATA_WIDTH: beat data.
- `M_AXIS_TSTRB` out C_M_AXIS_TDATA_WIDTH/8: byte strobes. All ones whenever TVALID=1, 0 otherwise.
- `M_AXIS_TLAST` out 1: last beat of packet.
- `M_AXIS_TREADY` in 1: downstream ready.
- `USR_tcm_busy` out 1: high whenever state ≠ IDLE.
- `USR_tcm_pkt_count` out 16: count of completed packets. Wraps 0xFFFF→0x0000.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- **IDLE**
  - ENABLE=1: latch LEN into `len_q`, clear `beat`, go to SEND.
  - ENABLE=0: stay in IDLE.
- **SEND**
  - TVALID=1.
  - TDATA[31:0] = {pkt_count[15:0], beat[15:0]}.
  - TLAST=1 iff beat == len_q.
  - A beat completes on TVALID&TREADY; `beat` then increments.
  - On the TLAST handshake, pkt_count increments and the next state is chosen:
    - CONTINUOUS=1 and ENABLE=1, gap>0 → GAP.
    - CONTINUOUS=1 and ENABLE=1, gap=0 → SEND, with a fresh `len_q` latched and `beat` cleared.
    - Otherwise → DONE.
- **GAP**: holds TVALID=0 for `gap` cycles. Then:
  - ENABLE=1: latch LEN, go to SEND.
  - ENABLE=0: go to IDLE.
- **DONE**: waits for ENABLE=0, then goes to IDLE. Single-shot mode re-arms only on an ENABLE low→high sequence.
- Control is sampled only at packet start and at FSM decision points. LEN changing mid-packet has no effect on the current packet.
- ENABLE dropping mid-packet: the packet completes in full. Packets are never truncated.
- AXI-Stream rules:
  - Once TVALID=1, it stays high until the handshake.
  - TDATA, TLAST and TSTRB stay stable while TVALID=1 and TREADY=0.
  - TVALID never depends combinationally on TREADY.
- LEN=0 gives one-beat packets with TLAST=1 on the only beat.
- LEN=0xFFFF gives 65536 beats. `beat` is 16 bits and stops at len_q, so no overflow.

## Timing
- All outputs are registered.
- Reset values: TVALID=0, TLAST=0, TSTRB=0, TDATA=0, busy=0, pkt_count=0, state=IDLE.
- Reset asserted mid-packet drops TVALID immediately, asynchronously. No TLAST is emitted.
- Start latency: ENABLE sampled high in IDLE at edge N gives TVALID=1 after edge N.
- With TREADY held high, throughput is one beat per cycle, with no bubbles inside a packet.
- Continuous mode, gap=0: the first beat of the next packet is valid in the cycle immediately after the TLAST handshake. There is no idle cycle.
- Continuous mode, gap=G: exactly G cycles with TVALID=0 between the TLAST handshake and the next first beat.
- `USR_tcm_pkt_count` updates on the edge of the TLAST handshake.
- Control comes from the AXI-Lite domain, which shares this clock. There is no synchroniser.

## Configuration
- `TCM_AXIS_TX_GAP_EN`
  - Defined: GAP field [7:4] is honoured; the GAP state and a 4-bit gap counter are built.
  - Undefined: gap is forced to 0; the GAP state and counter are not built; continuous packets are back-to-back. Bits [7:4] are ignored.

## Test plan
- **Single-shot:** control=0x0003_0001, TREADY=1.
  - Expect 4 beats, TDATA 0x0000_0000…0x0000_0003, TLAST on beat 3.
  - Expect pkt_count=1, state DONE.
  - No further beats until ENABLE toggles 0→1.
- **Backpressure:** same control, TREADY pattern 1,0,0,1,0,1,1.
  - TDATA/TLAST hold while TREADY=0.
  - Exactly 4 handshakes, values as above.
- **Continuous, no gap:** control=0x0001_0003.
  - Beats 0x0000_0000, 0x0000_0001(TLAST), 0x0001_0000, 0x0001_0001(TLAST)…
  - TVALID never drops.
- **Continuous with gap** (macro defined): control=0x0000_0033, i.e. LEN=0, GAP=3, CONTINUOUS=1, ENABLE=1.
  - One-beat packets with TLAST=1, separated by exactly 3 TVALID=0 cycles.
  - Macro undefined: no separating cycles.
- **ENABLE drop mid-packet:** LEN=7, clear ENABLE after beat 2.
  - All 8 beats are still sent, TLAST on beat 7, then IDLE.
- **Async reset mid-packet:**
  - Assert ARESETN=0 during beat 3: TVALID, busy and pkt_count go 0 without waiting for a clock edge.
  - After release with ENABLE=1: a fresh packet starts at beat 0, pkt_count 0.
